mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Round-robin arbiter sharing the single port of the node's 2K×16 parameter RAM (Q-values, HCM table, neighbour count) among the compute blocks (best-Q search, Q-update, packet handler, host loader). Each requester holds ownership with a req/gnt handshake for an arbitrary burst. The owner's address, write strobe and write data are routed to the RAM, and RAM read data is broadcast to all requesters. The block sits in the top level between the compute blocks and the RAM macro.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 11, RAM address width
- DW, 16, RAM data width
- MAX_HOLD, 1024, maximum grant cycles per burst (used only with timeout feature)

Ports:
- clock  in  1  rising-edge clock
- nrst  in  1  synchronous, active-low reset
- req  in  NREQ  per-requester ownership request, level
- wr  in  NREQ  per-requester write strobe, valid only while granted
- addr  in  NREQ*AW  per-requester address, requester i at bits [i*AW +: AW]
- wdata  in  NREQ*DW  per-requester write data, same packing
- gnt  out  NREQ  one-hot grant, registered
- rdata  out  DW  RAM read data broadcast (= mem_rdata)
- mem_addr  out  AW  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, synchronous, 1-cycle latency
- busy  out  1  high while any grant is held
- owner  out  3  index of current/last owner
- err_timeout  out  1  one-cycle pulse on forced release

## Operation
- Reset: gnt=0, busy=0, owner=NREQ-1 (so requester 0 has top priority first), err_timeout=0, hold counter=0.
- States: IDLE (no grant) and OWNED (gnt[owner]=1).
- IDLE: when any req is high, the block picks the first requester scanning owner+1, owner+2, … modulo NREQ. At the next edge it sets gnt for that requester, updates owner and moves to OWNED.
- OWNED with req[owner]=1: the grant is held. Other requests are ignored.
- OWNED with req[owner]=0: the grant is released at the next edge. At that same edge the block arbitrates among the other requests (rotation starting at owner+1). If a winner exists, it goes straight to OWNED with the new owner and there is no idle cycle. Otherwise the block returns to IDLE.
- Datapath, combinational from the registered gnt:
  - mem_addr = addr[owner], mem_wdata = wdata[owner], mem_we = wr[owner].
  - With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- wr from a requester that is not granted is ignored.
- Simultaneous requests: exactly one grant. Rotation guarantees every requester is served within NREQ-1 bursts of the others.

## Timing
- req rises at edge n → gnt visible after edge n+1 when the block is IDLE.
- Address presented in cycle c → mem_rdata/rdata valid in cycle c+1, independent of grant changes.
- Owner drops req in cycle c → its gnt is low after edge c+1, and the next owner's gnt is high after edge c+1.
- A requester that raises req in the same cycle the owner drops req competes normally in that rotation.
- Reset mid-burst: all grants drop after the reset edge, and mem_we is 0 from then on.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A hold counter increments every OWNED cycle and clears on each new grant.
  - When the counter reaches MAX_HOLD, the grant is forcibly revoked, err_timeout pulses for 1 cycle, and arbitration proceeds as for a release.
  - The offending requester is then masked until it deasserts req for at least one cycle.
- ARB_TIMEOUT_EN undefined: no counter and no mask. err_timeout is tied to 0 and grants are held indefinitely.

## Structure
- The shared package holds the RAM map constants (neighbour count 0x68A, Q-value base 0x1C8, HCM base 0x648), DW/AW defaults and the owner index width.
- One sub-module, rr_pick: combinational rotate-priority encoder (req vector, start index) → (valid, index).

## Test plan
- Reset, then req=4'b0001 → gnt=4'b0001 after 1 edge; mem_addr follows addr[0]=0x68A; mem_rdata 0x0003 appears on rdata in the next cycle.
- req=4'b1111 held, each owner drops req after 3 cycles → grant order 0,1,2,3,0 with no idle cycles between bursts.
- Owner 2 writes wr=1, addr=0x1CA, wdata=0x1234 while requester 1 asserts wr=1 ungranted → exactly one RAM write (0x1CA ← 0x1234).
- All req drop → gnt=0, busy=0, mem_we=0 next cycle; owner keeps its last value.
- Reset asserted mid-write burst → gnt=0 and mem_we=0 after the reset edge; the next grant goes to requester 0.
- With ARB_TIMEOUT_EN and MAX_HOLD=8, requester 1 holds req → revoked after 8 cycles, err_timeout pulses once, requester 3 (pending) is granted, and requester 1 is not re-granted until it toggles req.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter_pkg : parameter-RAM map constants and arbiter types      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package mem_port_arbiter_pkg;

  localparam int DEF_AW  = 11;
  localparam int DEF_DW  = 16;
  localparam int OWNER_W = 3;

  localparam logic [DEF_AW-1:0] ADDR_NBR_CNT   = 11'h68A;
  localparam logic [DEF_AW-1:0] ADDR_QVAL_BASE = 11'h1C8;
  localparam logic [DEF_AW-1:0] ADDR_HCM_BASE  = 11'h648;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter_rr_pick : rotate-priority encoder, first set bit at or   |
// | after start_i (modulo N). Rev 1.0                                          |
// +--------------------------------------------------------------------------+
module mem_port_arbiter_rr_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]       req_i,
  input  logic [OWNER_W-1:0] start_i,
  output logic               valid_o,
  output logic [OWNER_W-1:0] idx_o
);

  logic [N-1:0]     rot;
  logic [OWNER_W:0] sum;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    rot     = N'({req_i, req_i} >> start_i);
    // Descending scan so the nearest position after start_i wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, start_i} + (OWNER_W + 1)'(i);
        if (sum >= (OWNER_W + 1)'(N)) begin
          sum = sum - (OWNER_W + 1)'(N);
        end
        valid_o = 1'b1;
        idx_o   = sum[OWNER_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter : round-robin owner of the parameter-RAM port.           |
// | Optional forced release via macro ARB_TIMEOUT_EN. Rev 1.0                  |
// +--------------------------------------------------------------------------+
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int MAX_HOLD = 1024
) (
  input  logic                 clock,
  input  logic                 nrst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      wr,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [DW-1:0]        rdata,
  output logic [AW-1:0]        mem_addr,
  output logic                 mem_we,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  output logic                 busy,
  output logic [OWNER_W-1:0]   owner,
  output logic                 err_timeout
);

  arb_state_e         state_q, state_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [OWNER_W-1:0] start;
  logic [NREQ-1:0]    cand;
  logic [NREQ-1:0]    mask;
  logic               timeout;
  logic               owner_req;
  logic               new_grant;
  logic               pick_valid;
  logic [OWNER_W-1:0] pick_idx;

  // The current owner is excluded so a release always hands over or idles.
  assign start     = (owner_q == OWNER_W'(NREQ - 1)) ? '0 : owner_q + OWNER_W'(1);
  assign cand      = req & ~mask & ~gnt_q;
  assign owner_req = |(req & gnt_q);

  mem_port_arbiter_rr_pick #(.N(NREQ)) u_pick (
    .req_i   (cand),
    .start_i (start),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= OWNER_W'(NREQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    new_grant = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d   = ST_OWNED;
          gnt_d     = NREQ'(1) << pick_idx;
          owner_d   = pick_idx;
          new_grant = 1'b1;
        end
      end
      ST_OWNED: begin
        if (!owner_req || timeout) begin
          if (pick_valid) begin
            gnt_d     = NREQ'(1) << pick_idx;
            owner_d   = pick_idx;
            new_grant = 1'b1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end
      end
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [NREQ-1:0]   mask_q, mask_d;
  logic              err_q, err_d;

  assign timeout     = (state_q == ST_OWNED) && (hold_q == HOLD_W'(MAX_HOLD - 1));
  assign mask        = mask_q;
  assign err_timeout = err_q;

  // A revoked requester stays masked until it is seen with req low.
  always_comb begin
    hold_d = '0;
    if (!new_grant && state_q == ST_OWNED) begin
      hold_d = hold_q + HOLD_W'(1);
    end
    mask_d = (mask_q & req) | (timeout ? gnt_q : '0);
    err_d  = timeout;
  end

  always_ff @(posedge clock) begin
    if (!nrst) begin
      hold_q <= '0;
      mask_q <= '0;
      err_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      mask_q <= mask_d;
      err_q  <= err_d;
    end
  end
`else
  logic hold_unused;

  assign hold_unused = new_grant ^ (MAX_HOLD > 0);
  assign timeout     = 1'b0;
  assign mask        = '0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        mem_addr  = mem_addr | addr[i*AW +: AW];
        mem_wdata = mem_wdata | wdata[i*DW +: DW];
      end
    end
  end

  assign mem_we = |(wr & gnt_q);
  assign gnt    = gnt_q;
  assign busy   = |gnt_q;
  assign owner  = owner_q;
  assign rdata  = mem_rdata;

endmodule
`default_nettype wire
